// File: rtl/iter_shift_pkg.sv
// Shared definitions for the iterative shifter: ALU function codes
// and the decode helper used to recognise shift operations.
package iter_shift_pkg;

    localparam logic [3:0] FUNC_LLS = 4'h4;
    localparam logic [3:0] FUNC_LRS = 4'h5;
    localparam logic [3:0] FUNC_ALS = 4'h6;
    localparam logic [3:0] FUNC_ARS = 4'h7;

    function automatic logic is_shift_func(input logic [3:0] f);
        return (f == FUNC_LLS) || (f == FUNC_LRS) ||
               (f == FUNC_ALS) || (f == FUNC_ARS);
    endfunction

endpackage

// File: rtl/iter_shift_step.sv
// One-bit shift step; reports whether the top bit changed so the
// caller can track arithmetic-left overflow.
module shift_step
    import iter_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [3:0]            func,
    output logic [DATA_WIDTH-1:0] nxt,
    output logic                  chg
);

    always_comb begin
        nxt = value;
        unique case (1'b1)
            (func == FUNC_LLS) || (func == FUNC_ALS):
                nxt = {value[DATA_WIDTH-2:0], 1'b0};
            (func == FUNC_LRS):
                nxt = {1'b0, value[DATA_WIDTH-1:1]};
            (func == FUNC_ARS):
                nxt = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
            default:
                nxt = value;
        endcase
        chg = nxt[DATA_WIDTH-1] ^ value[DATA_WIDTH-1];
    end

endmodule

// File: rtl/iter_shift.sv
// Iterative shifter: one bit per cycle, valid/ready on both sides,
// result held in DONE until the consumer takes it.
module iter_shift
    import iter_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            FuncCode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] WIDTH_V =
        DATA_WIDTH[DATA_WIDTH-1:0];
    localparam logic [CW-1:0] WIDTH_C = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] work;
    logic [3:0]            func;
    logic                  ovf;
    logic                  rdy;
    logic                  vld;

    logic [DATA_WIDTH-1:0] step_nxt;
    logic                  step_chg;
    logic [CW-1:0]         n_eff;
    logic                  known;

    shift_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .value(work),
        .func (func),
        .nxt  (step_nxt),
        .chg  (step_chg)
    );

    // Oversized shift amounts saturate at the full width.
    always_comb begin
        n_eff = WIDTH_C;
        if (B < WIDTH_V)
            n_eff = B[CW-1:0];
        known = is_shift_func(FuncCode);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            func  <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        func <= FuncCode;
                        ovf  <= 1'b0;
                        rdy  <= 1'b0;
                        if (!known) begin
                            work  <= '0;
                            cnt   <= '0;
                            state <= DONE;
                            vld   <= 1'b1;
                        end else if (n_eff == '0) begin
                            work  <= A;
                            cnt   <= '0;
                            state <= DONE;
                            vld   <= 1'b1;
                        end else begin
                            work  <= A;
                            cnt   <= n_eff;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_nxt;
                    cnt  <= cnt - ONE_C;
                    if (func == FUNC_ALS && step_chg)
                        ovf <= 1'b1;
                    if (cnt == ONE_C) begin
                        state <= DONE;
                        vld   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = rdy;
    assign out_valid    = vld;
    assign C            = work;
    assign OverflowFlag = ovf;

endmodule

// File: tb/tb_iter_shift.sv
// Self-checking bench for iter_shift: directed table, corner
// sequences and randomized ops against an arithmetic model.
module tb_iter_shift;
    import iter_shift_pkg::*;

    localparam int DW = 16;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [3:0]    FuncCode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] C;
    logic          OverflowFlag;

    int nvec = 0;
    int nmis = 0;

    iter_shift #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .FuncCode    (FuncCode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .C           (C),
        .OverflowFlag(OverflowFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    f;
        logic [DW-1:0] c;
        logic          ovf;
        int            lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: shift by the saturated amount in one go.
    function automatic void model(input logic [DW-1:0] a,
                                  input logic [DW-1:0] b,
                                  input logic [3:0] f,
                                  output logic [DW-1:0] c,
                                  output logic ovf,
                                  output int lat);
        int n;
        logic [31:0] x;
        logic [31:0] t;
        logic [31:0] mask;
        logic signed [31:0] s;
        n = (b < 16'(DW)) ? int'(b) : DW;
        c = '0;
        ovf = 1'b0;
        lat = 1;
        if (is_shift_func(f)) begin
            lat = (n == 0) ? 1 : n + 1;
            s = {{16{a[DW-1]}}, a};
            if (f == FUNC_LLS || f == FUNC_ALS)
                c = 16'({16'h0, a} << n);
            else if (f == FUNC_LRS)
                c = 16'({16'h0, a} >> n);
            else
                c = 16'(s >>> n);
            if (f == FUNC_ALS) begin
                x = {a, 16'h0};
                t = x >> (31 - n);
                mask = (32'd1 << (n + 1)) - 32'd1;
                ovf = (t != 32'd0) && (t != mask);
            end
        end
    endfunction

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [3:0] f, output logic [DW-1:0] c,
                          output logic ovf, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        A = a;
        B = b;
        FuncCode = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        FuncCode = 4'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) lat = -1;
        c = C;
        ovf = OverflowFlag;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] c;
        logic [DW-1:0] ec;
        logic [DW-1:0] hold;
        logic ovf;
        logic eovf;
        int lat;
        int elat;
        int seen;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [3:0] rf;

        tbl[0]  = '{16'h0001, 16'd4,     FUNC_LLS, 16'h0010, 1'b0, 5};
        tbl[1]  = '{16'h8000, 16'd3,     FUNC_ARS, 16'hF000, 1'b0, 4};
        tbl[2]  = '{16'h8000, 16'd3,     FUNC_LRS, 16'h1000, 1'b0, 4};
        tbl[3]  = '{16'h4000, 16'd1,     FUNC_ALS, 16'h8000, 1'b1, 2};
        tbl[4]  = '{16'hC000, 16'd1,     FUNC_ALS, 16'h8000, 1'b0, 2};
        tbl[5]  = '{16'h1234, 16'd0,     FUNC_LLS, 16'h1234, 1'b0, 1};
        tbl[6]  = '{16'h8001, 16'h0100,  FUNC_ARS, 16'hFFFF, 1'b0, 17};
        tbl[7]  = '{16'h1234, 16'd3,     4'h0,     16'h0000, 1'b0, 1};
        tbl[8]  = '{16'hFFFF, 16'd16,    FUNC_LLS, 16'h0000, 1'b0, 17};
        tbl[9]  = '{16'h0001, 16'd15,    FUNC_ALS, 16'h8000, 1'b1, 16};
        tbl[10] = '{16'hFFFF, 16'd20,    FUNC_LRS, 16'h0000, 1'b0, 17};
        tbl[11] = '{16'h5A5A, 16'd0,     FUNC_ALS, 16'h5A5A, 1'b0, 1};

        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        FuncCode = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", 32'(C), 32'd0);
        chk("rst_ovf", 32'(OverflowFlag), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].f, c, ovf, lat);
            chk($sformatf("tbl%0d_c", i), 32'(c), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Reset in the middle of a long shift.
        @(negedge clk);
        A = 16'h0001;
        B = 16'd10;
        FuncCode = FUNC_LLS;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_c", 32'(C), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_stale", 32'(seen), 32'd0);

        // Backpressure in DONE with in_valid pulsing.
        @(negedge clk);
        A = 16'h0003;
        B = 16'd2;
        FuncCode = FUNC_LLS;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp_done", 32'(seen), 32'd1);
        hold = C;
        chk("bp_c", 32'(hold), 32'h000C);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            A = 16'($urandom);
            B = 16'd1;
            FuncCode = FUNC_LRS;
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i),
                {C, 13'h0, out_valid, in_ready, OverflowFlag},
                {hold, 13'h0, 1'b1, 1'b0, 1'b0});
        end
        A = 16'h0005;
        B = 16'd1;
        FuncCode = FUNC_LLS;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle", {30'h0, in_ready, out_valid}, {30'h0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accept", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_next", {15'h0, out_valid, C}, {15'h0, 1'b1, 16'h000A});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Randomized operations against the model.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                             : 16'($urandom_range(0, 18));
            rf = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                             : 4'(4 + $urandom_range(0, 3));
            model(ra, rb, rf, ec, eovf, elat);
            run_op(ra, rb, rf, c, ovf, lat);
            chk($sformatf("rnd%0d_c a=%h b=%h f=%h", i, ra, rb, rf),
                32'(c), 32'(ec));
            chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(eovf));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/iter_shift.md
ITER_SHIFT -- requirements
Module: iter_shift

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A  input  DATA_WIDTH  operand to shift.
REQ-007 B  input  DATA_WIDTH  shift amount, unsigned.
REQ-008 FuncCode  input  4  operation select, FUNC_LLS/FUNC_LRS/FUNC_ALS/FUNC_ARS from the shared ALU function-code include.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 C  output  DATA_WIDTH  shifted result.
REQ-012 OverflowFlag  output  1  signed overflow during FUNC_ALS; 0 otherwise.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid 0; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; A, B and FuncCode SHALL be captured then and ignored afterwards.
REQ-016 Effective count N SHALL equal B when B < DATA_WIDTH, else DATA_WIDTH.
REQ-017 On accept: N=0 or unrecognized FuncCode -> DONE next cycle; otherwise -> SHIFT with count register = N.
REQ-018 Each SHIFT cycle SHALL apply one 1-bit step to the working register and decrement the count; at count 1 the step completes and the next state is DONE.
REQ-019 Step rules: LLS and ALS shift left with 0 fill; LRS shifts right with 0 fill; ARS shifts right replicating bit DATA_WIDTH-1.
REQ-020 Latency from accept edge to out_valid=1 SHALL be N+1 cycles for N>=1, and 1 cycle for N=0 or unrecognized FuncCode.
REQ-021 N=0 SHALL return C=A, OverflowFlag=0.
REQ-022 Unrecognized FuncCode SHALL return C=0, OverflowFlag=0.
REQ-023 OverflowFlag SHALL be set, for FUNC_ALS only, if any step changes bit DATA_WIDTH-1 of the working register; once set it remains set until the next accept.
REQ-024 In DONE, out_valid SHALL be 1 and C/OverflowFlag stable until a rising edge with out_ready=1, which returns the block to IDLE.
REQ-025 A new request SHALL NOT be accepted in the cycle the result is consumed; the earliest accept is the following IDLE cycle.
REQ-026 in_valid asserted during SHIFT or DONE SHALL have no effect.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, C=0, OverflowFlag=0 and clear the count, regardless of clock.
REQ-028 Reset mid-SHIFT or mid-DONE SHALL discard the operation; no out_valid SHALL follow release.
REQ-029 Deassertion of reset_n SHALL take effect at the next rising edge of clk.

Structure
REQ-030 FuncCode values SHALL come from the shared ALU function-code include; state encodings are local to iter_shift.
REQ-031 The 1-bit step SHALL be a combinational sub-module shift_step (inputs value and FuncCode; outputs next value and sign-change bit).
REQ-032 Count register width SHALL be clog2(DATA_WIDTH)+1 bits.

Verification
REQ-033 Reset: assert reset_n=0 mid-SHIFT -> in_ready=1, out_valid=0, C=0 immediately; no stale result after release.
REQ-034 FUNC_LLS, A=16'h0001, B=4 -> C=16'h0010, OverflowFlag=0, out_valid 5 cycles after accept.
REQ-035 FUNC_ARS, A=16'h8000, B=3 -> C=16'hF000; FUNC_LRS same operands -> C=16'h1000.
REQ-036 FUNC_ALS, A=16'h4000, B=1 -> C=16'h8000, OverflowFlag=1; A=16'hC000, B=1 -> C=16'h8000, OverflowFlag=0.
REQ-037 Boundaries: B=0 -> C=A after 1 cycle; B=16'h0100 with FUNC_ARS, A=16'h8001 -> C=16'hFFFF after 17 cycles; FuncCode unrecognized -> C=0 after 1 cycle.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE -> C stable, in_valid ignored; out_ready=1 -> IDLE next cycle, new request accepted the cycle after.
